adsr_env: RTL

Attack/decay/sustain/release envelope controller for one synth voice. It drives the `amp` input of the amplitude stage between the oscillator (sine/saw) and the PDM modulator. It sequences level over time from a note gate, with live-programmable rates and sustain level. All level updates are paced by an internal tick divider, so envelope times are independent of audio sample rate.

---
 rtl/adsr_env.sv | 123 ++++++++++++
 1 files changed

// File: rtl/adsr_env.sv
// ADSR envelope controller for one synth voice.
// Level updates are paced by a free-running tick divider; gate events take
// priority over the tick, so a tick that coincides with a gate edge is dropped.
module adsr_env #(
  parameter int unsigned NBITS    = 10,
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic [NBITS-1:0] attack_rate,
  input  logic [NBITS-1:0] decay_rate,
  input  logic [NBITS-1:0] sustain_level,
  input  logic [NBITS-1:0] release_rate,
  output logic [NBITS-1:0] amp,
  output logic             busy,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [NBITS:0] MAX_W    = {1'b0, {NBITS{1'b1}}};

  state_t            state_q, state_d;
  logic [NBITS-1:0]  amp_q, amp_d;
  logic              gate_d;
  logic [CW-1:0]     cnt;
  logic              tick;
  logic              rise;
  logic [NBITS:0]    sum;
  logic signed [NBITS:0] diff;
  logic signed [NBITS:0] sus_s;

  assign tick  = (cnt == TICK_LAST);
  assign rise  = gate & ~gate_d;
  // Extra bit keeps the add from wrapping and the decay difference signed
  assign sum   = {1'b0, amp_q} + {1'b0, attack_rate};
  assign diff  = $signed({1'b0, amp_q}) - $signed({1'b0, decay_rate});
  assign sus_s = $signed({1'b0, sustain_level});

  assign amp   = amp_q;
  assign state = state_q;
  assign busy  = (state_q != IDLE);

  // Free-running tick divider, restarted by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // State, level and gate history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      amp_q   <= '0;
      gate_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      gate_d  <= gate;
    end
  end

  // Next state and level: retrigger, then gate-off, then tick update
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (!gate && (state_q == ATTACK || state_q == DECAY ||
                           state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        ATTACK: begin
          if (attack_rate == '0 || sum >= MAX_W) begin
            amp_d   = '1;
            state_d = DECAY;
          end else begin
            amp_d = sum[NBITS-1:0];
          end
        end
        DECAY: begin
          if (decay_rate == '0 || diff <= sus_s) begin
            amp_d   = sustain_level;
            state_d = SUSTAIN;
          end else begin
            amp_d = diff[NBITS-1:0];
          end
        end
        SUSTAIN: begin
          amp_d = sustain_level;
        end
        RELEASE: begin
          if (release_rate == '0 || amp_q <= release_rate) begin
            amp_d   = '0;
            state_d = IDLE;
          end else begin
            amp_d = amp_q - release_rate;
          end
        end
        default: begin
          amp_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
